// File: rtl/alu_exec_pkg.sv
// Shared opcode, FSM state and width defaults for the alu_exec execute stage.
package alu_exec_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_e;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_MUL  = 1'b1;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per edge over 16 edges after start_i.
// done_o and product_o are combinational so the caller can register the result on the final edge.
module seq_mul #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         done_o,
  output logic [W-1:0] product_o
);

  logic         active_q;
  logic [3:0]   cnt_q;
  logic [W-1:0] acc_q;
  logic [W-1:0] mcand_q;
  logic [W-1:0] mplier_q;
  logic [W-1:0] partial_s;
  logic [W-1:0] sum_s;

  assign partial_s = mplier_q[0] ? mcand_q : '0;
  assign sum_s     = acc_q + partial_s;
  assign done_o    = active_q && (cnt_q == 4'd15);
  assign product_o = sum_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= 4'd0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= 4'd0;
      acc_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
    end else if (active_q) begin
      acc_q    <= sum_s;
      mcand_q  <= {mcand_q[W-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[W-1:1]};
      cnt_q    <= cnt_q + 4'd1;
      active_q <= !done_o;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Single-issue execute stage writing results straight into the register file.
// Define ALU_EXEC_MUL_EN to build the 16-cycle MUL path; otherwise op 7 is a no-writeback no-op.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              flag_z
);

  logic              accept_s;
  logic              is_mul_s;
  logic              wb_en_s;
  logic [ADDR_W-1:0] wb_addr_s;
  logic [DATA_W-1:0] wb_data_s;
  logic [DATA_W-1:0] alu_res_s;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              flag_z_q;

  assign accept_s = in_valid && in_ready;
  assign is_mul_s = (op == OP_MUL);

  // Shift amounts use only src_b[3:0]; carries and borrows fall off the top.
  always_comb begin
    alu_res_s = '0;
    case (alu_op_e'(op))
      OP_ADD:  alu_res_s = src_a + src_b;
      OP_SUB:  alu_res_s = src_a - src_b;
      OP_AND:  alu_res_s = src_a & src_b;
      OP_OR:   alu_res_s = src_a | src_b;
      OP_XOR:  alu_res_s = src_a ^ src_b;
      OP_SHL:  alu_res_s = src_a << src_b[3:0];
      OP_SHR:  alu_res_s = src_a >> src_b[3:0];
      default: alu_res_s = '0;
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] mul_dst_q;
  logic              mul_start_s;
  logic              mul_done_s;
  logic [DATA_W-1:0] mul_prod_s;

  assign mul_start_s = accept_s && is_mul_s;

  seq_mul #(
    .W(DATA_W)
  ) u_seq_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mul_start_s),
    .a_i      (src_a),
    .b_i      (src_b),
    .done_o   (mul_done_s),
    .product_o(mul_prod_s)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (mul_start_s) state_d = ST_MUL;
        else             state_d = ST_IDLE;
      end
      ST_MUL: begin
        if (mul_done_s) state_d = ST_IDLE;
        else            state_d = ST_MUL;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mul_dst_q <= '0;
    end else begin
      state_q <= state_d;
      if (mul_start_s) mul_dst_q <= dst;
    end
  end

  // No single-cycle accept can coincide with mul completion since in_ready is low in ST_MUL.
  always_comb begin
    if (mul_done_s) begin
      wb_en_s   = 1'b1;
      wb_addr_s = mul_dst_q;
      wb_data_s = mul_prod_s;
    end else begin
      wb_en_s   = accept_s && !is_mul_s;
      wb_addr_s = dst;
      wb_data_s = alu_res_s;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_MUL);
`else
  assign wb_en_s   = accept_s && !is_mul_s;
  assign wb_addr_s = dst;
  assign wb_data_s = alu_res_s;
  assign in_ready  = 1'b1;
  assign busy      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      flag_z_q  <= 1'b0;
    end else begin
      wr_en_q <= wb_en_s;
      if (wb_en_s) begin
        wr_addr_q <= wb_addr_s;
        wr_data_q <= wb_data_s;
        flag_z_q  <= (wb_data_s == '0);
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign flag_z  = flag_z_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec; MUL scenarios run only when ALU_EXEC_MUL_EN is defined.
module tb_alu_exec;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] src_a;
  logic [15:0] src_b;
  logic [3:0]  dst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        flag_z;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .dst     (dst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .flag_z  (flag_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b, input logic [3:0] d);
    in_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    dst      = d;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    op       = 3'd0;
    src_a    = 16'h0000;
    src_b    = 16'h0000;
    dst      = 4'd0;
    repeat (2) step();
    n_checks++;
    if ({wr_en, wr_addr, wr_data, flag_z, busy} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%h z=%b busy=%b, want all 0", wr_en, wr_addr, wr_data, flag_z, busy);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_add();
    drive(3'd0, 16'hB274, 16'hEA7C, 4'd1);
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({wr_en, wr_addr, wr_data, flag_z} !== {1'b1, 4'd1, 16'h9CF0, 1'b0}) begin
      n_fail++;
      $display("FAIL add: got en=%b addr=%0d data=%h z=%b, want 1 1 9cf0 0", wr_en, wr_addr, wr_data, flag_z);
    end
    step();
    n_checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b0, 4'd1, 16'h9CF0}) begin
      n_fail++;
      $display("FAIL add_hold: got en=%b addr=%0d data=%h, want 0 1 9cf0", wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_back_to_back();
    drive(3'd1, 16'h0005, 16'h0005, 4'd2);
    step();
    n_checks++;
    if ({wr_en, wr_addr, wr_data, flag_z} !== {1'b1, 4'd2, 16'h0000, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_sub: got en=%b addr=%0d data=%h z=%b, want 1 2 0000 1", wr_en, wr_addr, wr_data, flag_z);
    end
    drive(3'd5, 16'h8277, 16'h0001, 4'd3);
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({wr_en, wr_addr, wr_data, flag_z} !== {1'b1, 4'd3, 16'h04EE, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_shl: got en=%b addr=%0d data=%h z=%b, want 1 3 04ee 0", wr_en, wr_addr, wr_data, flag_z);
    end
    step();
    n_checks++;
    if (wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: got en=%b want 0", wr_en);
    end
  endtask

  task automatic test_logic_ops();
    logic [2:0]  ops  [6] = '{3'd2, 3'd3, 3'd4, 3'd6, 3'd6, 3'd0};
    logic [15:0] av   [6] = '{16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h8000, 16'h8000, 16'hFFFF};
    logic [15:0] bv   [6] = '{16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h000F, 16'h0013, 16'h0001};
    logic [3:0]  dv   [6] = '{4'd7, 4'd8, 4'd0, 4'd15, 4'd9, 4'd0};
    logic [15:0] ev   [6] = '{16'h3030, 16'hFCFC, 16'hCCCC, 16'h0001, 16'h1000, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], av[i], bv[i], dv[i]);
      step();
      n_checks++;
      if ({wr_en, wr_addr, wr_data, flag_z} !== {1'b1, dv[i], ev[i], (ev[i] == 16'h0000)}) begin
        n_fail++;
        $display("FAIL logic_op[%0d]: got en=%b addr=%0d data=%h z=%b, want 1 %0d %h %b",
                 i, wr_en, wr_addr, wr_data, flag_z, dv[i], ev[i], (ev[i] == 16'h0000));
      end
    end
    in_valid = 1'b0;
    step();
  endtask

`ifdef ALU_EXEC_MUL_EN
  task automatic test_mul();
    int bad_cycles = 0;
    drive(3'd7, 16'h0003, 16'h0005, 4'd4);
    step();
    drive(3'd0, 16'h0001, 16'h0002, 4'd5);
    for (int i = 0; i < 16; i++) begin
      if (in_ready !== 1'b0 || busy !== 1'b1 || wr_en !== 1'b0) bad_cycles++;
      step();
    end
    n_checks++;
    if (bad_cycles != 0) begin
      n_fail++;
      $display("FAIL mul_busy: got %0d bad busy cycles, want 0", bad_cycles);
    end
    n_checks++;
    if ({wr_en, wr_addr, wr_data, busy, in_ready} !== {1'b1, 4'd4, 16'h000F, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mul_wb: got en=%b addr=%0d data=%h busy=%b rdy=%b, want 1 4 000f 0 1",
               wr_en, wr_addr, wr_data, busy, in_ready);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd5, 16'h0003}) begin
      n_fail++;
      $display("FAIL mul_held_add: got en=%b addr=%0d data=%h, want 1 5 0003", wr_en, wr_addr, wr_data);
    end
    step();
  endtask

  task automatic test_reset_during_mul();
    int pulses = 0;
    drive(3'd7, 16'h0003, 16'h0005, 4'd6);
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({wr_en, wr_addr, wr_data, flag_z, busy} !== 23'd0) begin
      n_fail++;
      $display("FAIL mul_abort_reset: got en=%b addr=%0d data=%h z=%b busy=%b, want all 0", wr_en, wr_addr, wr_data, flag_z, busy);
    end
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_abort_ready: got %b want 1", in_ready);
    end
    for (int i = 0; i < 20; i++) begin
      if (wr_en !== 1'b0) pulses++;
      step();
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL mul_abort_nowb: got %0d wr_en pulses, want 0", pulses);
    end
  endtask
`else
  task automatic test_op7_disabled();
    int pulses = 0;
    drive(3'd2, 16'h00FF, 16'hFF00, 4'd10);
    step();
    n_checks++;
    if ({wr_en, wr_data, flag_z} !== {1'b1, 16'h0000, 1'b1}) begin
      n_fail++;
      $display("FAIL op7_setup: got en=%b data=%h z=%b, want 1 0000 1", wr_en, wr_data, flag_z);
    end
    drive(3'd7, 16'h0003, 16'h0005, 4'd11);
    for (int i = 0; i < 3; i++) begin
      step();
      if (wr_en !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL op7_nowb: got %0d bad cycles, want 0", pulses);
    end
    n_checks++;
    if ({wr_addr, wr_data, flag_z} !== {4'd10, 16'h0000, 1'b1}) begin
      n_fail++;
      $display("FAIL op7_hold: got addr=%0d data=%h z=%b, want 10 0000 1", wr_addr, wr_data, flag_z);
    end
    drive(3'd0, 16'h0001, 16'h0001, 4'd12);
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({wr_en, wr_addr, wr_data, flag_z} !== {1'b1, 4'd12, 16'h0002, 1'b0}) begin
      n_fail++;
      $display("FAIL op7_next_add: got en=%b addr=%0d data=%h z=%b, want 1 12 0002 0", wr_en, wr_addr, wr_data, flag_z);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_logic_ops();
`ifdef ALU_EXEC_MUL_EN
    test_mul();
    test_reset_during_mul();
`else
    test_op7_disabled();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter DATA_W, default 16, operand/result width; matches register-file data width.
REQ-002 Parameter ADDR_W, default 4, destination register address width (16 registers).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream presents an operation this cycle.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
REQ-008 src_a  input  DATA_W  operand A, driven from register-file read port 1.
REQ-009 src_b  input  DATA_W  operand B, driven from register-file read port 2.
REQ-010 dst  input  ADDR_W  destination register address.
REQ-011 wr_en  output  1  one-cycle write strobe to the register-file write enable.
REQ-012 wr_addr  output  ADDR_W  write address to the register file.
REQ-013 wr_data  output  DATA_W  write data to the register file.
REQ-014 busy  output  1  multi-cycle operation in progress.
REQ-015 flag_z  output  1  zero flag of the last writeback.

Function
REQ-016 Accept SHALL occur on a rising edge where in_valid and in_ready are both 1; op, src_a, src_b and dst are sampled on that edge.
REQ-017 FSM states SHALL be IDLE and MUL; in_ready = 1 only in IDLE; busy = 1 only in MUL.
REQ-018 Ops 0-6 SHALL complete in one cycle: on the accept edge, wr_addr = dst, wr_data = result, and wr_en = 1 for exactly the following cycle; FSM stays in IDLE.
REQ-019 Back-to-back single-cycle accepts SHALL produce one wr_en pulse per accept with no bubbles.
REQ-020 ADD/SUB results SHALL wrap modulo 2^DATA_W with carry/borrow discarded; SHL/SHR SHALL be logical shifts by src_b[3:0] with zero fill.
REQ-021 MUL SHALL use a shift-add multiplier: the accept edge enters MUL and clears a 4-bit counter; 16 further edges iterate; on the 16th iteration edge wr_data = low DATA_W bits of the product, wr_en = 1 for one cycle, and the FSM returns to IDLE.
REQ-022 in_valid while busy SHALL be ignored; upstream holds the operation until in_ready = 1.
REQ-023 wr_en SHALL be 0 in every cycle without a completing operation; wr_addr and wr_data SHALL hold their last values.
REQ-024 flag_z SHALL update only on writeback edges, set to 1 when written wr_data == 0; otherwise it holds.
REQ-025 dst = 0 SHALL be written like any other address (no hard-wired zero register).

Reset
REQ-026 While rst_n = 0: FSM = IDLE, wr_en = 0, wr_addr = 0, wr_data = 0, flag_z = 0, busy = 0, counter = 0; in_ready = 1 after release.
REQ-027 Reset asserted during MUL SHALL abort the operation with no writeback, then or later.

Configuration
REQ-028 Macro ALU_EXEC_MUL_EN defined: MUL is supported as specified in REQ-021.
REQ-029 ALU_EXEC_MUL_EN undefined: no multiplier logic; op 7 is accepted in one cycle with no writeback; wr_en, flag_z and FSM are unaffected; busy is constant 0.

Structure
REQ-030 Package alu_exec_pkg SHALL hold the opcode enum, DATA_W/ADDR_W defaults and the FSM state typedef.
REQ-031 Sub-module seq_mul (iterative shift-add multiplier, start/done handshake) SHALL be instantiated only under ALU_EXEC_MUL_EN.

Verification
REQ-032 ADD: src_a = 16'hB274, src_b = 16'hEA7C, dst = 1 -> next cycle wr_en = 1, wr_addr = 1, wr_data = 16'h9CF0, flag_z = 0.
REQ-033 SUB 16'h0005 - 16'h0005 to dst 2, then SHL 16'h8277 by 1 to dst 3 on consecutive edges -> two consecutive wr_en pulses: (2, 16'h0000, flag_z = 1), then (3, 16'h04EE, flag_z = 0).
REQ-034 MUL 16'h0003 × 16'h0005 to dst 4 -> in_ready = 0 and busy = 1 for 16 cycles; a held ADD is not accepted during this time; wr_en pulse with wr_data = 16'h000F, wr_addr = 4; the ADD is accepted the cycle after.
REQ-035 MUL accepted, rst_n pulled low 5 cycles later -> no wr_en pulse; all outputs at reset values; in_ready = 1 after release.
REQ-036 Build without ALU_EXEC_MUL_EN, issue op 7 -> accepted in one cycle; wr_en stays 0; flag_z unchanged; busy stays 0.
